// File: rtl/exu_gpr_wb_arb.sv
// exu_gpr_wb_arb: round-robin writeback arbiter for the shared GPR write port.
// Grants one handler request per cycle, holds it in a one-entry writeback
// stage, drives the GPR write port from that stage, and forwards the staged
// value to the two read-port lookups.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wreq_vld/idx/data, wreq_rdy      per-channel write requests and grant
//   wb_stall                         freeze the stage, block grants and writes
//   gpr_w_en/idx/data                GPR write port
//   fwd_idx0/1, fwd_hit0/1, fwd_data0/1  read-port forwarding lookups
module exu_gpr_wb_arb #(
  parameter int unsigned CHN_NUM = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHN_NUM-1:0]       wreq_vld,
  input  logic [CHN_NUM*IDX_W-1:0] wreq_idx,
  input  logic [CHN_NUM*XLEN-1:0]  wreq_data,
  output logic [CHN_NUM-1:0]       wreq_rdy,
  input  logic                     wb_stall,
  output logic                     gpr_w_en,
  output logic [IDX_W-1:0]         gpr_w_idx,
  output logic [XLEN-1:0]          gpr_w_data,
  input  logic [IDX_W-1:0]         fwd_idx0,
  input  logic [IDX_W-1:0]         fwd_idx1,
  output logic                     fwd_hit0,
  output logic                     fwd_hit1,
  output logic [XLEN-1:0]          fwd_data0,
  output logic [XLEN-1:0]          fwd_data1
);

  localparam int unsigned PTR_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             stg_vld_q, stg_vld_d;
  logic [IDX_W-1:0] stg_idx_q, stg_idx_d;
  logic [XLEN-1:0]  stg_data_q, stg_data_d;

  logic [IDX_W-1:0]   req_idx  [CHN_NUM];
  logic [XLEN-1:0]    req_data [CHN_NUM];
  logic [CHN_NUM-1:0] rdy_c;
  logic               gnt_vld_c;
  logic [PTR_W-1:0]   gnt_ch_c;
  logic [SUM_W-1:0]   scan_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic [XLEN-1:0]    gnt_data_c;

  // Unpack the flat request buses into per-channel views.
  always_comb begin
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      req_idx[i]  = wreq_idx[i*IDX_W +: IDX_W];
      req_data[i] = wreq_data[i*XLEN +: XLEN];
    end
  end

  // Round-robin scan starting at ptr, wrapping modulo CHN_NUM; first valid wins.
  always_comb begin
    rdy_c     = '0;
    gnt_vld_c = 1'b0;
    gnt_ch_c  = '0;
    scan_c    = '0;
    if (!wb_stall) begin
      for (int unsigned k = 0; k < CHN_NUM; k++) begin
        scan_c = SUM_W'(ptr_q) + SUM_W'(k);
        if (scan_c >= SUM_W'(CHN_NUM)) begin
          scan_c = scan_c - SUM_W'(CHN_NUM);
        end
        if (!gnt_vld_c && wreq_vld[scan_c[PTR_W-1:0]]) begin
          gnt_vld_c = 1'b1;
          gnt_ch_c  = scan_c[PTR_W-1:0];
        end
      end
    end
    if (gnt_vld_c) begin
      rdy_c[gnt_ch_c] = 1'b1;
    end
  end

  assign gnt_idx_c  = req_idx[gnt_ch_c];
  assign gnt_data_c = req_data[gnt_ch_c];

  // Next state: pointer advance past the winner, stage load unless stalled.
  // A granted write to x0 is accepted but never marks the stage valid.
  always_comb begin
    ptr_d      = ptr_q;
    stg_vld_d  = stg_vld_q;
    stg_idx_d  = stg_idx_q;
    stg_data_d = stg_data_q;
    if (!wb_stall) begin
      stg_vld_d  = gnt_vld_c & (gnt_idx_c != '0);
      stg_idx_d  = gnt_vld_c ? gnt_idx_c  : '0;
      stg_data_d = gnt_vld_c ? gnt_data_c : '0;
    end
    if (gnt_vld_c) begin
      ptr_d = (gnt_ch_c == PTR_W'(CHN_NUM - 1)) ? '0 : gnt_ch_c + PTR_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_idx_q  <= '0;
      stg_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_idx_q  <= stg_idx_d;
      stg_data_q <= stg_data_d;
    end
  end

  assign wreq_rdy   = rdy_c;
  assign gpr_w_en   = stg_vld_q & ~wb_stall;
  assign gpr_w_idx  = stg_idx_q;
  assign gpr_w_data = stg_data_q;

  // Forwarding stays valid while stalled; x0 lookups never hit.
  assign fwd_hit0  = stg_vld_q & (stg_idx_q == fwd_idx0) & (fwd_idx0 != '0);
  assign fwd_hit1  = stg_vld_q & (stg_idx_q == fwd_idx1) & (fwd_idx1 != '0);
  assign fwd_data0 = stg_data_q;
  assign fwd_data1 = stg_data_q;

endmodule

// File: tb/tb_exu_gpr_wb_arb.sv
// Self-checking bench for exu_gpr_wb_arb: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_exu_gpr_wb_arb;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      wreq_vld;
  logic [N*IW-1:0]   wreq_idx;
  logic [N*XW-1:0]   wreq_data;
  logic [N-1:0]      wreq_rdy;
  logic              wb_stall;
  logic              gpr_w_en;
  logic [IW-1:0]     gpr_w_idx;
  logic [XW-1:0]     gpr_w_data;
  logic [IW-1:0]     fwd_idx0, fwd_idx1;
  logic              fwd_hit0, fwd_hit1;
  logic [XW-1:0]     fwd_data0, fwd_data1;

  always #5 clk = ~clk;

  exu_gpr_wb_arb #(.CHN_NUM(N), .XLEN(XW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wreq_vld(wreq_vld), .wreq_idx(wreq_idx), .wreq_data(wreq_data),
    .wreq_rdy(wreq_rdy), .wb_stall(wb_stall),
    .gpr_w_en(gpr_w_en), .gpr_w_idx(gpr_w_idx), .gpr_w_data(gpr_w_data),
    .fwd_idx0(fwd_idx0), .fwd_idx1(fwd_idx1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
  );

  // Requester-side stimulus state (held until granted).
  bit            r_vld  [N];
  logic [IW-1:0] r_idx  [N];
  logic [XW-1:0] r_data [N];
  bit            t_stall;
  logic [IW-1:0] t_f0, t_f1;

  // Reference model: pointer and one-entry stage.
  int            m_ptr;
  bit            m_vld;
  logic [IW-1:0] m_idx;
  logic [XW-1:0] m_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int c = 0; c < N; c++) begin
      wreq_vld[c]            = r_vld[c];
      wreq_idx[c*IW +: IW]   = r_idx[c];
      wreq_data[c*XW +: XW]  = r_data[c];
    end
    wb_stall = t_stall;
    fwd_idx0 = t_f0;
    fwd_idx1 = t_f1;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_vld  = 1'b0;
    m_idx  = '0;
    m_data = '0;
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(output int g, output logic [N-1:0] rdy_seen);
    logic [N-1:0] exp_rdy;
    bit           eh0, eh1;
    @(negedge clk);
    apply();
    #1;
    g = -1;
    exp_rdy = '0;
    if (!t_stall) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && r_vld[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    rdy_seen = wreq_rdy;
    chk("rdy", 64'(wreq_rdy), 64'(exp_rdy));
    chk("w_en", 64'(gpr_w_en), 64'(m_vld && !t_stall));
    if (m_vld) begin
      chk("w_idx", 64'(gpr_w_idx), 64'(m_idx));
      chk("w_data", 64'(gpr_w_data), 64'(m_data));
    end
    eh0 = m_vld && (m_idx == t_f0) && (t_f0 != '0);
    eh1 = m_vld && (m_idx == t_f1) && (t_f1 != '0);
    chk("hit0", 64'(fwd_hit0), 64'(eh0));
    chk("hit1", 64'(fwd_hit1), 64'(eh1));
    if (eh0) chk("fdata0", 64'(fwd_data0), 64'(m_data));
    if (eh1) chk("fdata1", 64'(fwd_data1), 64'(m_data));
    @(posedge clk);
    if (!t_stall) begin
      m_vld = 1'b0;
      if (g >= 0) begin
        m_vld  = (r_idx[g] != '0);
        m_idx  = r_idx[g];
        m_data = r_data[g];
        m_ptr  = (g + 1) % N;
      end
    end
    if (g >= 0) r_vld[g] = 1'b0;
  endtask

  task automatic req(input int c, input int idx, input logic [XW-1:0] data);
    r_vld[c]  = 1'b1;
    r_idx[c]  = IW'(idx);
    r_data[c] = data;
  endtask

  int            g;
  logic [N-1:0]  rs;
  logic [N-1:0]  one_hot;

  initial begin
    for (int c = 0; c < N; c++) begin
      r_vld[c] = 1'b0; r_idx[c] = '0; r_data[c] = '0;
    end
    t_stall = 1'b0; t_f0 = '0; t_f1 = '0;
    model_reset();
    rst_n = 1'b0;
    apply();
    #1;
    // Reset state.
    chk("rst_w_en", 64'(gpr_w_en), 64'd0);
    chk("rst_w_idx", 64'(gpr_w_idx), 64'd0);
    chk("rst_w_data", 64'(gpr_w_data), 64'd0);
    chk("rst_hit0", 64'(fwd_hit0), 64'd0);
    chk("rst_fdata1", 64'(fwd_data1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with continuous requests from all channels.
    for (int c = 0; c < N; c++) req(c, c + 1, XW'(32'hA0 + c));
    for (int n = 0; n < 5; n++) begin
      step(g, rs);
      one_hot = '0;
      one_hot[n % N] = 1'b1;
      chk("rr_rdy", 64'(rs), 64'(one_hot));
      if (g >= 0) r_vld[g] = 1'b1;
    end
    for (int c = 0; c < N; c++) r_vld[c] = 1'b0;
    step(g, rs);

    // Write to x0 is accepted and dropped.
    req(2, 0, 32'hDEAD);
    step(g, rs);
    chk("x0_rdy", 64'(rs), 64'(4'b0100));
    step(g, rs);

    // Wrap from ptr=3: channel 3 then channel 0, then ptr is 1.
    req(0, 9, 32'h900);
    req(3, 10, 32'hA00);
    step(g, rs);
    chk("wrap_rdy3", 64'(rs), 64'(4'b1000));
    step(g, rs);
    chk("wrap_rdy0", 64'(rs), 64'(4'b0001));
    req(0, 11, 32'hB00);
    req(1, 12, 32'hC00);
    step(g, rs);
    chk("wrap_ptr1", 64'(rs), 64'(4'b0010));
    step(g, rs);

    // Stall holds the staged x7 write and forwards it meanwhile.
    req(1, 7, 32'h55);
    step(g, rs);
    chk("stall_gnt", 64'(rs), 64'(4'b0010));
    t_stall = 1'b1;
    t_f0 = 5'd7;
    req(0, 3, 32'h66);
    for (int n = 0; n < 3; n++) begin
      step(g, rs);
      chk("stall_rdy", 64'(rs), 64'd0);
    end
    t_stall = 1'b0;
    step(g, rs);
    chk("unstall_gnt", 64'(rs), 64'(4'b0001));
    step(g, rs);
    t_f0 = '0;

    // Forwarding of a freshly granted write, then no hit once it drains.
    req(0, 5, 32'h1234);
    step(g, rs);
    t_f1 = 5'd5;
    step(g, rs);
    step(g, rs);
    t_f1 = '0;

    // Reset mid-operation discards the staged entry.
    req(2, 12, 32'hBEEF);
    step(g, rs);
    @(negedge clk);
    t_f0 = 5'd12;
    apply();
    rst_n = 1'b0;
    #1;
    chk("mrst_w_en", 64'(gpr_w_en), 64'd0);
    chk("mrst_hit0", 64'(fwd_hit0), 64'd0);
    chk("mrst_w_idx", 64'(gpr_w_idx), 64'd0);
    model_reset();
    for (int c = 0; c < N; c++) r_vld[c] = 1'b0;
    t_f0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req(0, 13, 32'hD00);
    req(3, 14, 32'hE00);
    step(g, rs);
    chk("mrst_prio", 64'(rs), 64'(4'b0001));

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N; c++) begin
        if (!r_vld[c] && ($urandom % 3 == 0)) req(c, int'($urandom % 8), $urandom);
      end
      t_stall = ($urandom % 5 == 0);
      t_f0 = IW'($urandom % 8);
      t_f1 = IW'($urandom % 8);
      step(g, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
